// File: rtl/imem_loader.sv
// imem_loader: write-side loader for the word-organised instruction memory.
// Takes a byte stream (valid/ready), reads a 16-bit little-endian word count,
// assembles little-endian 32-bit words and writes them from address 0 upward,
// keeping busy high until the image is in place.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit checksum byte (sum mod 256 of all data bytes) before reporting done.
module imem_loader #(
  parameter int address_width = 12,
  parameter int data_width    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  // One extra bit so that a count equal to the full depth is representable.
  localparam int          word_idx_w = address_width - 1;
  localparam logic [16:0] depth      = 17'd1 << (address_width - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

  // Where the frame goes once its last word (or an empty body) is handled.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHECK;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [word_idx_w-1:0]   word_idx_q, word_idx_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [data_width-1:0]   word_q, word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  logic        xfer;
  logic [15:0] len_full;

  assign xfer     = byte_valid && byte_ready;
  assign len_full = {byte_in, count_q[7:0]};

  // Register update; the assembled word is an ordinary register, so it is reset too.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state, datapath next values and handshake outputs.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_LEN_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          count_d[7:0] = byte_in;
          state_d      = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) begin
          count_d[15:8] = byte_in;
          if (len_full == 16'd0) begin
            state_d = S_END;
          end else if ({1'b0, len_full} > depth) begin
            state_d = S_ERROR;
          end else begin
            state_d    = S_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (xfer) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_in;
`endif
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        word_idx_d = word_idx_q + word_idx_w'(1);
        if (17'(word_idx_q) + 17'd1 == {1'b0, count_q}) state_d = S_END;
        else                                            state_d = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (xfer) state_d = (byte_in == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_address = {word_idx_q[address_width-3:0], 2'b00};
  assign mem_wdata   = word_q;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames plus hand-written corner sequences;
// expected memory writes go into a scoreboard queue as bytes are driven and
// are popped and compared whenever the loader pulses mem_we.
module tb_imem_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_in;
  logic          byte_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata;

  imem_loader #(.address_width(AW), .data_width(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         word_ptr;
  logic [7:0] tb_sum;

  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(mem_address), 64'(mon_e.addr));
        check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    word_ptr = 0;
    tb_sum   = 8'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) check("byte_ready_timeout", 0, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    wr_t e;
    e.addr = AW'(word_ptr * 4);
    e.data = w;
    exp_q.push_back(e);
    word_ptr++;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      tb_sum = tb_sum + w[8*k +: 8];
      repeat ((gap != 0) ? (k % 2) * gap : 0) @(posedge clk);
      if (gap != 0) #1;
    end
  endtask

  task automatic send_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(tb_sum);
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic finish_check(input string name, input logic exp_done, input logic exp_err);
    wait_idle(name);
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_busy"}, 64'(busy), 0);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    word_ptr = 0; tb_sum = 8'd0;

    vecs[0] = '{16'd2,     32'h00A00513, 32'h00B00593, 1'b1, 1'b0};
    vecs[1] = '{16'd1,     32'h12345678, 32'h0,        1'b1, 1'b0};
    vecs[2] = '{16'd0,     32'h0,        32'h0,        1'b1, 1'b0};
    vecs[3] = '{16'd1025,  32'h0,        32'h0,        1'b0, 1'b1};
    vecs[4] = '{16'd1,     32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[5] = '{16'hFFFF,  32'h0,        32'h0,        1'b0, 1'b1};
    vecs[6] = '{16'd2,     32'hCAFEF00D, 32'h0BADC0DE, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 64'(byte_ready), 0);
    check("rst_mem_we", 64'(mem_we), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_addr", 64'(mem_address), 0);
    check("rst_wdata", 64'(mem_wdata), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames, back-to-back bytes.
    for (int i = 0; i < 7; i++) begin
      pulse_start();
      check($sformatf("v%0d_busy_after_start", i), 64'(busy), 1);
      check($sformatf("v%0d_sticky_cleared", i), 64'({done, error}), 0);
      send_len(vecs[i].len);
      if (!vecs[i].exp_err) begin
        if (vecs[i].len >= 16'd1) send_word(vecs[i].w0, 0);
        if (vecs[i].len >= 16'd2) send_word(vecs[i].w1, 0);
        send_checksum();
      end
      finish_check($sformatf("v%0d", i), vecs[i].exp_done, vecs[i].exp_err);
    end

    // Bytes offered while idle in DONE are refused and leave DONE untouched.
    byte_in = 8'h55; byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_refuses_byte", 64'(byte_ready), 0);
      check("done_held", 64'(done), 1);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;

    // Same two-word frame with byte_valid dropping between bytes and longer stalls.
    pulse_start();
    send_len(16'd2);
    send_word(32'h00A00513, 1);
    repeat (3) @(posedge clk);
    #1;
    send_word(32'h00B00593, 2);
    send_checksum();
    finish_check("stall", 1'b1, 1'b0);

    // Reset in the middle of the second word: no write for the partial word.
    pulse_start();
    send_len(16'd2);
    send_word(32'h11223344, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    #1;
    check("midrst_byte_ready", 64'(byte_ready), 0);
    check("midrst_mem_we", 64'(mem_we), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_flags", 64'({done, error}), 0);
    check("midrst_addr", 64'(mem_address), 0);
    check("midrst_wdata", 64'(mem_wdata), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_sb_empty", 64'(exp_q.size()), 0);
    check("midrst_idle", 64'(busy), 0);
    pulse_start();
    send_len(16'd1);
    send_word(32'hA5A5_0F0F, 0);
    send_checksum();
    finish_check("after_rst", 1'b1, 1'b0);

    // Full-depth image: last write lands at 0xFFC; a start mid-load is ignored.
    pulse_start();
    send_len(16'd1024);
    for (int i = 0; i < 1024; i++) begin
      if (i == 100) start = 1'b1;
      send_word($urandom, 0);
      if (i == 100) begin
        start = 1'b0;
        check("start_ignored_busy", 64'(busy), 1);
      end
    end
    send_checksum();
    finish_check("full_depth", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum byte 0x14 matches 78+56+34+12 mod 256.
    pulse_start();
    send_len(16'd1);
    send_word(32'h12345678, 0);
    send_byte(8'h14);
    finish_check("csum_good", 1'b1, 1'b0);

    // Wrong checksum: the word is still written, then the load ends in error.
    pulse_start();
    send_len(16'd1);
    send_word(32'h12345678, 0);
    send_byte(8'h15);
    finish_check("csum_bad", 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
